round_pack16: RTL
=================

# round_pack16

Half-precision result normalizer, rounder and packer for the FP16 add/sub datapath. Sits after the operand special-case unit and the significand adder. It accepts either a raw signed-exponent/extended-significand result or a pre-resolved special result, normalizes it with one shift per cycle, rounds to nearest-even, packs IEEE-754 binary16 and raises UF/OF/INEXACT/INVALID. Valid/ready handshake on both sides.

## Interface
- No parameters; all widths fixed for binary16.
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  input word valid
- IN_READY  output  1  block can accept; high only in IDLE
- IN_EXC  input  1  special result already resolved upstream; bypass normalize/round
- IN_EXC_Q  input  16  special result (NaN/Inf/zero/passthrough) used when IN_EXC=1
- IN_INVALID  input  1  invalid-operation indication (e.g. Inf-Inf), copied to FLAGS[4]
- IN_SIGN  input  1  result sign
- IN_EXP  input  7  signed two's-complement biased exponent (bias 15), range -64..63
- IN_MANT  input  15  [14]=carry, [13]=hidden, [12:3]=fraction, [2]=guard, [1]=round, [0]=sticky
- OUT_VALID  output  1  result valid; held until accepted
- OUT_READY  input  1  downstream accepts
- OUT_Q  output  16  packed binary16 result
- OUT_FLAGS  output  5  [4]=INVALID, [3]=DIVZERO (always 0), [2]=UF, [1]=OF, [0]=INEXACT

## Operation
- States: IDLE, SHIFT, ROUND, OUT.
- IDLE: IN_READY=1. On IN_VALID: capture all inputs. If IN_EXC, go to OUT with OUT_Q=IN_EXC_Q and FLAGS={IN_INVALID,4'b0}. Otherwise go to SHIFT.
- SHIFT, one action per cycle, evaluated in priority order:
  - mant==0: exact zero; go to ROUND.
  - mant[14]=1: shift right 1, sticky|=shifted-out bit, exp+1.
  - exp<1: shift right 1, sticky-OR, exp+1. After 15 consecutive right shifts, the whole mantissa collapses into sticky.
  - mant[13]=0 and exp>1: shift left 1, exp-1.
  - Otherwise go to ROUND.
- ROUND (RNE):
  - Round up when G and (R|S|lsb).
  - A carry into bit 14 shifts right once and increments exp.
  - INEXACT = G|R|S.
  - Encoded exponent is 0 if bit13=0, else exp.
  - exp≥31 after rounding: OUT_Q={sign,5'h1F,10'h0}, OF=1, INEXACT=1.
  - UF=1 when the pre-round result was tiny (exp<1 on entry to SHIFT alignment, or bit13=0 at exp=1) and INEXACT.
  - Zero result: OUT_Q={IN_SIGN,15'h0}; sign policy is the upstream's job.
- OUT: OUT_VALID=1. OUT_Q and OUT_FLAGS stay stable while OUT_READY=0. On OUT_VALID&OUT_READY go to IDLE.
- Internal width: exponent register 8-bit signed; no wrap is possible in the input range.

## Timing
- Reset values: OUT_VALID=0, OUT_Q=16'h0000, OUT_FLAGS=5'b0, state=IDLE. IN_READY=0 while RST is high, 1 on the first cycle after RST falls.
- RST mid-operation aborts immediately. The captured word is discarded and nothing is output.
- Accept at edge k:
  - Bypass: OUT_VALID at k+1.
  - Normal input needing no shift: SHIFT at k+1, ROUND at k+2, OUT_VALID at k+3.
  - Each extra shift adds 1 cycle. Worst case is 15 right shifts, giving OUT_VALID at k+18.
- IN_READY is a registered-state decode. The block does not accept a new input in the same cycle an output is taken, so throughput is at most one result per latency+1 cycles.
- OUT_VALID does not drop without a handshake.

## Configuration
- ROUND16_FTZ_EN defined (flush-to-zero): a tiny result skips right-shifting. It outputs {sign,15'h0} with UF=1 and INEXACT=1, and goes SHIFT→ROUND with no denormalizing.
- ROUND16_FTZ_EN undefined: gradual underflow to subnormals as described in Operation.

## Structure
- Shared package fp16_pkg holds:
  - constants EXP_MAX=5'h1F, BIAS=15, QNAN=16'h7E00;
  - flag bit indices FLAG_INVALID/DIVZERO/UF/OF/INEXACT;
  - the state enum.
- Sub-module fp16_rne_round: combinational RNE increment, carry and INEXACT on the aligned 15-bit mantissa. It is instantiated once in ROUND.

## Test plan
- 1.0: IN_EXP=15, IN_MANT=15'h2000 -> OUT_Q=16'h3C00, FLAGS=0, OUT_VALID at k+3. Hold OUT_READY=0 for 4 cycles -> output stable.
- Carry: IN_EXP=15, IN_MANT=15'h4000 -> 16'h4000, FLAGS=0, OUT_VALID at k+4.
- Tie to even: IN_EXP=15, IN_MANT=15'h200C -> 16'h3C02, FLAGS=5'b00001.
- Overflow: IN_EXP=30, IN_MANT=15'h3FFC -> 16'h7C00, FLAGS=5'b00011.
- Bypass: IN_EXC=1, IN_EXC_Q=16'h7E00, IN_INVALID=1 -> 16'h7E00, FLAGS=5'b10000 at k+1. RST asserted at k+2 of a following normal op -> OUT_VALID stays 0.
- Subnormal: IN_EXP=0, IN_MANT=15'h2000 -> 16'h0200, FLAGS=0. With ROUND16_FTZ_EN -> 16'h0000, FLAGS=5'b00101.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 datapath definitions: binary16 field constants, flag bit positions, and the normalizer state encoding.
// No logic; nothing to time.
// No handshake; imported by the round/pack block and its sub-module.
package fp16_pkg;

  localparam logic [4:0]  EXP_MAX = 5'h1F;
  localparam int          BIAS    = 15;
  localparam logic [15:0] QNAN    = 16'h7E00;

  // Positions inside the 5-bit flag word
  localparam int FLAG_INVALID = 4;
  localparam int FLAG_DIVZERO = 3;
  localparam int FLAG_UF      = 2;
  localparam int FLAG_OF      = 1;
  localparam int FLAG_INEXACT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/round_pack16_if.sv
// Handshake bundle between the significand adder, round_pack16 and its consumer.
// No logic; latency is defined by the block it connects.
// Backpressure: valid/ready on both sides (in_valid/in_ready, out_valid/out_ready).
// Ports: input word (in_exc, in_exc_q, in_invalid, in_sign, in_exp, in_mant) and result (out_q, out_flags).
// master = upstream producer / downstream consumer side; slave = round_pack16.
interface round_pack16_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_exc;
  logic [15:0] in_exc_q;
  logic        in_invalid;
  logic        in_sign;
  logic [6:0]  in_exp;    // signed, biased by 15
  logic [14:0] in_mant;   // carry, hidden, 10 fraction bits, guard, round, sticky
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic [4:0]  out_flags;

  modport master (
    output in_valid, in_exc, in_exc_q, in_invalid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_q, out_flags
  );

  modport slave (
    input  in_valid, in_exc, in_exc_q, in_invalid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_q, out_flags
  );
endinterface

// File: rtl/fp16_rne_round.sv
// Round-to-nearest-even increment on an aligned 15-bit significand (bit 14 clear on entry).
// Latency: combinational.
// Backpressure: none; pure function of its input.
// Ports: mant in; sig = hidden+fraction after rounding (already renormalised on carry),
// carry = rounding overflowed into bit 14 (caller bumps the exponent), inexact = any of G/R/S set.
module fp16_rne_round (
  input  logic [14:0] mant,
  output logic [10:0] sig,
  output logic        carry,
  output logic        inexact
);
  logic        round_up;
  logic [11:0] rounded;

  // lsb participates only to break an exact tie toward even
  assign round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
  assign rounded  = mant[14:3] + {11'b0, round_up};
  assign carry    = rounded[11];
  // On carry the fraction is all zeros, so dropping the low bit is exact
  assign sig      = carry ? rounded[11:1] : rounded[10:0];
  assign inexact  = |mant[2:0];
endmodule

// File: rtl/round_pack16.sv
// FP16 normalizer/rounder/packer: one shift per cycle, RNE, binary16 pack with INVALID/UF/OF/INEXACT.
// Latency: bypass 1 cycle, normal 3 cycles + 1 per shift (15 right shifts max, 18 cycles).
// Backpressure: in_ready only in IDLE; result held in OUT until out_ready; no accept on the take cycle.
// Ports: clk, rst (async active-high), bus (round_pack16_if.slave).
// Build option: define ROUND16_FTZ_EN to flush tiny results to signed zero instead of denormalizing.
import fp16_pkg::*;

module round_pack16 (
  input  logic           clk,
  input  logic           rst,
  round_pack16_if.slave  bus
);

`ifdef ROUND16_FTZ_EN
  localparam bit FTZ_ON = 1'b1;
`else
  localparam bit FTZ_ON = 1'b0;
`endif

  state_t            state, state_nxt;
  logic              sign_r, invalid_r, ftz_r;
  logic signed [7:0] exp_r;
  logic [14:0]       mant_r;
  logic [3:0]        rcnt_r;
  logic [15:0]       q_r;
  logic [4:0]        flags_r;

  // Shift-stage decisions, in priority order
  logic sh_zero, sh_carry, sh_under, sh_left, sh_flush, sh_done;
  assign sh_zero  = (mant_r == 15'h0);
  assign sh_carry = mant_r[14];
  assign sh_under = (exp_r < 8'sd1);
  assign sh_left  = !mant_r[13] && (exp_r > 8'sd1);
  assign sh_flush = FTZ_ON && !sh_zero && !sh_carry && sh_under;
  assign sh_done  = sh_zero || sh_flush || (!sh_carry && !sh_under && !sh_left);

  // Right shift keeps everything shifted out in the sticky bit. The 15th
  // consecutive one collapses the whole significand into sticky and lands on
  // exp=1, which bounds the latency for very negative exponents.
  logic [14:0]       mant_rsh;
  logic signed [7:0] exp_rsh;
  always_comb begin
    mant_rsh = {1'b0, mant_r[14:2], mant_r[1] | mant_r[0]};
    exp_rsh  = exp_r + 8'sd1;
    if (rcnt_r == 4'd14) begin
      mant_rsh = {14'b0, |mant_r};
      exp_rsh  = 8'sd1;
    end
  end

  // Rounding and packing
  logic [10:0]       rnd_sig;
  logic              rnd_carry, rnd_inexact, tiny;
  logic signed [7:0] exp_rnd;
  logic [15:0]       q_rnd;
  logic [4:0]        flags_rnd;

  fp16_rne_round u_rne (
    .mant    (mant_r),
    .sig     (rnd_sig),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  // Subnormal before rounding; anything with exp<1 has been aligned to exp=1 by now
  assign tiny = (exp_r == 8'sd1) && !mant_r[13];

  always_comb begin
    exp_rnd   = exp_r + $signed({7'b0, rnd_carry});
    q_rnd     = {sign_r, 15'h0};
    flags_rnd = 5'b0;
    flags_rnd[FLAG_INVALID] = invalid_r;
    flags_rnd[FLAG_DIVZERO] = 1'b0;
    if (mant_r == 15'h0) begin
      q_rnd = {sign_r, 15'h0};
    end else if (ftz_r || (FTZ_ON && tiny)) begin
      flags_rnd[FLAG_UF]      = 1'b1;
      flags_rnd[FLAG_INEXACT] = 1'b1;
    end else if (exp_rnd >= $signed({3'b000, EXP_MAX})) begin
      q_rnd                   = {sign_r, EXP_MAX, 10'h0};
      flags_rnd[FLAG_OF]      = 1'b1;
      flags_rnd[FLAG_INEXACT] = 1'b1;
    end else begin
      q_rnd                   = {sign_r, (rnd_sig[10] ? exp_rnd[4:0] : 5'd0), rnd_sig[9:0]};
      flags_rnd[FLAG_UF]      = tiny && rnd_inexact;
      flags_rnd[FLAG_INEXACT] = rnd_inexact;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.in_valid) state_nxt = bus.in_exc ? ST_OUT : ST_SHIFT;
      ST_SHIFT: if (sh_done) state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_OUT;
      ST_OUT:   if (bus.out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs (in_ready is masked by rst so nothing is taken during reset)
  always_comb begin
    bus.in_ready  = (state == ST_IDLE) && !rst;
    bus.out_valid = (state == ST_OUT);
    bus.out_q     = q_r;
    bus.out_flags = flags_r;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r    <= 1'b0;
      invalid_r <= 1'b0;
      ftz_r     <= 1'b0;
      exp_r     <= 8'sd0;
      mant_r    <= 15'h0;
      rcnt_r    <= 4'd0;
      q_r       <= 16'h0;
      flags_r   <= 5'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (bus.in_valid) begin
          sign_r    <= bus.in_sign;
          invalid_r <= bus.in_invalid;
          ftz_r     <= 1'b0;
          exp_r     <= {bus.in_exp[6], bus.in_exp};
          mant_r    <= bus.in_mant;
          rcnt_r    <= 4'd0;
          if (bus.in_exc) begin
            q_r     <= bus.in_exc_q;
            flags_r <= {bus.in_invalid, 4'b0};
          end
        end
        ST_SHIFT: begin
          if (sh_zero) begin
            mant_r <= mant_r;
          end else if (sh_carry || (sh_under && !sh_flush)) begin
            mant_r <= mant_rsh;
            exp_r  <= exp_rsh;
            rcnt_r <= rcnt_r + 4'd1;
          end else if (sh_flush) begin
            ftz_r <= 1'b1;
          end else if (sh_left) begin
            mant_r <= {mant_r[13:0], 1'b0};
            exp_r  <= exp_r - 8'sd1;
          end
        end
        ST_ROUND: begin
          q_r     <= q_rnd;
          flags_r <= flags_rnd;
        end
        default: ;
      endcase
    end
  end

endmodule
